// File: rtl/morse_encoder_fifo.sv
// Morse LED encoder with a character FIFO: buffers pre-encoded characters and plays them as timed LED intervals.
// Optional length checking is enabled by defining MORSE_LEN_CHECK_EN.
module morse_encoder_fifo #(
    parameter int CODE_W     = 8,
    parameter int LEN_W      = 4,
    parameter int UNIT_CYC   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              char_vald,
    input  logic [CODE_W-1:0] charcode_data,
    input  logic [LEN_W-1:0]  charlen_data,
    output logic              char_rdy,
    output logic              char_next,
    output logic              led_drv,
    output logic              busy,
    output logic              len_err
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(4 * UNIT_CYC);

    localparam logic [TMR_W-1:0] T_UNIT = TMR_W'(UNIT_CYC - 1);
    localparam logic [TMR_W-1:0] T_DASH = TMR_W'(3 * UNIT_CYC - 1);
    localparam logic [TMR_W-1:0] T_CGAP = TMR_W'(2 * UNIT_CYC - 1);
    localparam logic [TMR_W-1:0] T_WORD = TMR_W'(4 * UNIT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SYM_GAP,
        CHAR_GAP,
        WORD
    } state_t;

    // ---------------- character FIFO ----------------
    logic [CODE_W-1:0] mem_code [FIFO_DEPTH];
    logic [LEN_W-1:0]  mem_len  [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              full, empty, push, pop, len_bad;
    logic [LEN_W-1:0]  len_wr;
    logic [CODE_W-1:0] head_code;
    logic [LEN_W-1:0]  head_len;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign char_rdy  = !full;
    assign len_bad   = (charlen_data > LEN_W'(CODE_W));
    assign head_code = mem_code[rd_ptr[AW-1:0]];
    assign head_len  = mem_len[rd_ptr[AW-1:0]];

`ifdef MORSE_LEN_CHECK_EN
    // Oversized characters are consumed from the source but never stored.
    assign push   = char_vald && char_rdy && !len_bad;
    assign len_wr = charlen_data;

    always_ff @(posedge clock) begin
        if (reset) len_err <= 1'b0;
        else       len_err <= char_vald && char_rdy && len_bad;
    end
`else
    assign push    = char_vald && char_rdy;
    assign len_wr  = len_bad ? LEN_W'(CODE_W) : charlen_data;
    assign len_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            mem_code[wr_ptr[AW-1:0]] <= charcode_data;
            mem_len[wr_ptr[AW-1:0]]  <= len_wr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // ---------------- serialiser FSM ----------------
    state_t            state, state_n;
    logic [TMR_W-1:0]  timer, timer_n;
    logic [CODE_W-1:0] sreg, sreg_n;
    logic [LEN_W-1:0]  sym_cnt, sym_n;
    logic              expire, start, done;

    assign expire = (timer == '0);
    assign busy   = !empty || (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            sreg      <= '0;
            sym_cnt   <= '0;
            led_drv   <= 1'b0;
            char_next <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            sreg      <= sreg_n;
            sym_cnt   <= sym_n;
            led_drv   <= (state_n == MARK);
            char_next <= done;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = expire ? timer : timer - TMR_W'(1);
        sreg_n  = sreg;
        sym_n   = sym_cnt;
        start   = 1'b0;
        done    = 1'b0;
        pop     = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) start = 1'b1;
            end
            MARK: begin
                if (expire) begin
                    state_n = SYM_GAP;
                    timer_n = T_UNIT;
                    sreg_n  = sreg << 1;
                    sym_n   = sym_cnt - LEN_W'(1);
                end
            end
            SYM_GAP: begin
                if (expire) begin
                    if (sym_cnt != '0) begin
                        state_n = MARK;
                        timer_n = sreg[CODE_W-1] ? T_DASH : T_UNIT;
                    end else begin
                        state_n = CHAR_GAP;
                        timer_n = T_CGAP;
                    end
                end
            end
            CHAR_GAP, WORD: begin
                if (expire) begin
                    done = 1'b1;
                    if (!empty) start = 1'b1;
                    else        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Shared load path lets a gap expiry chain straight into the next character.
        if (start) begin
            pop    = 1'b1;
            sreg_n = head_code;
            sym_n  = head_len;
            if (head_len == '0) begin
                state_n = WORD;
                timer_n = T_WORD;
            end else begin
                state_n = MARK;
                timer_n = head_code[CODE_W-1] ? T_DASH : T_UNIT;
            end
        end
    end

endmodule
